// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared game state encoding, screen constants and LFSR constants
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } game_state_t;

    localparam int SCR_W       = 640;
    localparam int SCR_H       = 480;
    localparam int SCR_FLOOR_Y = 470;

    localparam logic [9:0] LFSR_SEED  = 10'h2A5;
    localparam int         LFSR_TAP_A = 9;
    localparam int         LFSR_TAP_B = 6;

endpackage

// File: rtl/obstacle_hit_check.sv
// rtl/obstacle_hit_check.sv - combinational bird-versus-single-obstacle overlap test
module obstacle_hit_check #(
    parameter int OBS_W   = 40,
    parameter int GAP_H   = 100,
    parameter int BIRD_SZ = 10
) (
    input  logic [9:0] bird_x,
    input  logic [9:0] bird_y,
    input  logic [9:0] obs_x,
    input  logic [9:0] obs_y,
    output logic       hit
);

    logic [10:0] bx, by, ox, oy;
    logic        overlap_x, in_gap;

    // 11-bit so that edge-plus-width sums never wrap
    assign bx = {1'b0, bird_x};
    assign by = {1'b0, bird_y};
    assign ox = {1'b0, obs_x};
    assign oy = {1'b0, obs_y};

    assign overlap_x = (bx + 11'(BIRD_SZ) > ox) && (ox + 11'(OBS_W) > bx);
    assign in_gap    = (by >= oy) && (by + 11'(BIRD_SZ) <= oy + 11'(GAP_H));
    assign hit       = overlap_x && !in_gap;

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - obstacle scroll/respawn, collision and score FSM; SCROLL_ACCEL_EN enables score-based speedup
module obstacle_scheduler
    import flappy_pkg::*;
#(
    parameter int START_X = 320,
    parameter int SPACING = 160,
    parameter int OBS_W   = 40,
    parameter int GAP_H   = 100,
    parameter int BIRD_SZ = 10,
    parameter int Y_MIN   = 40,
    parameter int Y_MAX   = 340,
    parameter int FLOOR_Y = SCR_FLOOR_Y,
    parameter int SPEED   = 2
) (
    input  logic       ClkPort,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] BirdXdraw,
    input  logic [9:0] BirdYdraw,
    output logic [9:0] X_Edge_O1,
    output logic [9:0] X_Edge_O2,
    output logic [9:0] X_Edge_O3,
    output logic [9:0] X_Edge_O4,
    output logic [9:0] Y_Edge_O1,
    output logic [9:0] Y_Edge_O2,
    output logic [9:0] Y_Edge_O3,
    output logic [9:0] Y_Edge_O4,
    output logic [1:0] game_state,
    output logic       collision,
    output logic [7:0] score
);

    localparam int RING = 4 * SPACING;
    localparam int SPAN = Y_MAX - Y_MIN;

    game_state_t state_q, state_d;
    logic        collision_q;
    logic [9:0]  x_q   [4];
    logic [9:0]  y_q   [4];
    logic [9:0]  x_nxt [4];
    logic [9:0]  y_nxt [4];
    logic [3:0]  passed;
    logic [3:0]  obs_hit;
    logic [9:0]  lfsr_q;
    logic [7:0]  score_q;
    logic [9:0]  speed;
    logic [8:0]  r;
    logic [9:0]  respawn_y;
    logic        floor_hit, any_hit;
    logic        scroll_en, reload;

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[8:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
    end

`ifdef SCROLL_ACCEL_EN
    logic [5:0] accel_sum;
    assign accel_sum = 6'(SPEED) + {1'b0, score_q[7:3]};
    assign speed     = (accel_sum > 6'd6) ? 10'd6 : {4'd0, accel_sum};
`else
    assign speed = 10'(SPEED);
`endif

    // Fold the 9-bit random value back into [0, SPAN]
    assign r         = lfsr_q[8:0];
    assign respawn_y = 10'(Y_MIN) + ((r > 9'(SPAN)) ? {1'b0, r - 9'(SPAN) - 9'd1} : {1'b0, r});

    for (genvar k = 0; k < 4; k++) begin : g_hit
        obstacle_hit_check #(
            .OBS_W  (OBS_W),
            .GAP_H  (GAP_H),
            .BIRD_SZ(BIRD_SZ)
        ) u_hit (
            .bird_x(BirdXdraw),
            .bird_y(BirdYdraw),
            .obs_x (x_q[k]),
            .obs_y (y_q[k]),
            .hit   (obs_hit[k])
        );
    end

    assign floor_hit = ({1'b0, BirdYdraw} + 11'(BIRD_SZ)) > 11'(FLOOR_Y);
    assign any_hit   = (|obs_hit) || floor_hit;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (x_q[k] >= speed) begin
                x_nxt[k] = x_q[k] - speed;
                y_nxt[k] = y_q[k];
            end else begin
                x_nxt[k] = x_q[k] + 10'(RING) - speed;
                y_nxt[k] = respawn_y;
            end
            passed[k] = (({1'b0, x_q[k]}   + 11'(OBS_W)) >  {1'b0, BirdXdraw}) &&
                        (({1'b0, x_nxt[k]} + 11'(OBS_W)) <= {1'b0, BirdXdraw});
        end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            collision_q <= (state_d == HIT);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (frame_tick && any_hit) state_d = HIT;
            HIT:     if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scroll_en = (state_q == RUN) && frame_tick && !any_hit;
        reload    = (state_q == HIT) && start;
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= 10'(START_X + k * SPACING);
                y_q[k] <= 10'(100 + k * 60);
            end
            score_q <= 8'd0;
        end else if (reload) begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= 10'(START_X + k * SPACING);
                y_q[k] <= 10'(100 + k * 60);
            end
            score_q <= 8'd0;
        end else if (scroll_en) begin
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= x_nxt[k];
                y_q[k] <= y_nxt[k];
            end
            if ((|passed) && (score_q != 8'hFF)) score_q <= score_q + 8'd1;
        end
    end

    assign X_Edge_O1  = x_q[0];
    assign X_Edge_O2  = x_q[1];
    assign X_Edge_O3  = x_q[2];
    assign X_Edge_O4  = x_q[3];
    assign Y_Edge_O1  = y_q[0];
    assign Y_Edge_O2  = y_q[1];
    assign Y_Edge_O3  = y_q[2];
    assign Y_Edge_O4  = y_q[3];
    assign game_state = state_q;
    assign collision  = collision_q;
    assign score      = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bird_x = 10'd200;
    logic [9:0] bird_y = 10'd200;
    logic [9:0] xo1, xo2, xo3, xo4, yo1, yo2, yo3, yo4;
    logic [1:0] game_state;
    logic       collision;
    logic [7:0] score;

    int checks = 0;
    int failures = 0;

    logic [9:0] m_lfsr;
    logic [9:0] exp_x1, old_x1, exp_y1;
    logic [8:0] cap_r;
    int         exp_score;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .ClkPort   (clk),
        .reset     (rst),
        .frame_tick(frame_tick),
        .start     (start),
        .BirdXdraw (bird_x),
        .BirdYdraw (bird_y),
        .X_Edge_O1 (xo1),
        .X_Edge_O2 (xo2),
        .X_Edge_O3 (xo3),
        .X_Edge_O4 (xo4),
        .Y_Edge_O1 (yo1),
        .Y_Edge_O2 (yo2),
        .Y_Edge_O3 (yo3),
        .Y_Edge_O4 (yo4),
        .game_state(game_state),
        .collision (collision),
        .score     (score)
    );

    // Reference x^10+x^7+1 sequence from the seed, stepping every clock
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 10'h2A5;
        else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic ft, input logic st);
        frame_tick = ft;
        start      = st;
        cap_r      = m_lfsr[8:0];
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
    endtask

    task automatic check_reset_positions(input string tag);
        check({tag, "_x1"}, 32'(xo1), 320);
        check({tag, "_x2"}, 32'(xo2), 480);
        check({tag, "_x3"}, 32'(xo3), 640);
        check({tag, "_x4"}, 32'(xo4), 800);
        check({tag, "_y1"}, 32'(yo1), 100);
        check({tag, "_y2"}, 32'(yo2), 160);
        check({tag, "_y3"}, 32'(yo3), 220);
        check({tag, "_y4"}, 32'(yo4), 280);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_reset_positions("rst");
        check("rst_state", 32'(game_state), 0);
        check("rst_score", 32'(score), 0);
        check("rst_coll", 32'(collision), 0);

        repeat (3) pulse(1'b1, 1'b0);
        check_reset_positions("idle");
        check("idle_state", 32'(game_state), 0);

        pulse(1'b0, 1'b1);
        check("start_state", 32'(game_state), 1);
        check("start_x1", 32'(xo1), 320);

        pulse(1'b1, 1'b0);
        check("f1_x1", 32'(xo1), 318);
        check("f1_x2", 32'(xo2), 478);
        check("f1_x3", 32'(xo3), 638);
        check("f1_x4", 32'(xo4), 798);
        check("f1_state", 32'(game_state), 1);

        // Bird at x=50 rides inside obstacle 1's gap [100,200)
        bird_x    = 10'd50;
        bird_y    = 10'd140;
        exp_x1    = 10'd318;
        exp_y1    = 10'd100;
        exp_score = 0;
        for (int t = 0; t < 160; t++) begin
            old_x1 = exp_x1;
            pulse(1'b1, 1'b0);
            if (old_x1 >= 10'd2) begin
                exp_x1 = old_x1 - 10'd2;
            end else begin
                exp_x1 = old_x1 + 10'd638;
                exp_y1 = (cap_r > 9'd300) ? 10'(40 + int'(cap_r) - 301) : 10'(40 + int'(cap_r));
            end
            if ((int'(old_x1) + 40 > 50) && (int'(exp_x1) + 40 <= 50)) exp_score++;
            check("run_score", 32'(score), 32'(exp_score));
        end
        check("wrap_x1", 32'(xo1), 638);
        check("wrap_y1", 32'(yo1), 32'(exp_y1));
        check("wrap_y1_range", 32'((yo1 >= 10'd40) && (yo1 <= 10'd340)), 1);
        check("wrap_x2", 32'(xo2), 158);
        check("wrap_x3", 32'(xo3), 318);
        check("wrap_x4", 32'(xo4), 478);
        check("wrap_score", 32'(score), 1);
        check("wrap_state", 32'(game_state), 1);

        // Bird in obstacle 2's column, above its gap [160,260)
        bird_x = 10'd160;
        bird_y = 10'd10;
        pulse(1'b1, 1'b0);
        check("hit_state", 32'(game_state), 2);
        check("hit_coll", 32'(collision), 1);
        check("hit_x2", 32'(xo2), 158);
        repeat (10) pulse(1'b1, 1'b0);
        check("frozen_x1", 32'(xo1), 638);
        check("frozen_x2", 32'(xo2), 158);
        check("frozen_score", 32'(score), 1);
        check("frozen_state", 32'(game_state), 2);

        pulse(1'b0, 1'b1);
        check("reload_state", 32'(game_state), 0);
        check("reload_coll", 32'(collision), 0);
        check("reload_score", 32'(score), 0);
        check_reset_positions("reload");

        // Floor rule, then start+tick together in HIT
        bird_x = 10'd200;
        bird_y = 10'd465;
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check("floor_state", 32'(game_state), 2);
        check("floor_x1", 32'(xo1), 320);
        pulse(1'b1, 1'b1);
        check("hit_both_state", 32'(game_state), 0);
        check("hit_both_x1", 32'(xo1), 320);

        // start+tick together in IDLE, then in RUN
        bird_y = 10'd200;
        pulse(1'b1, 1'b1);
        check("idle_both_state", 32'(game_state), 1);
        check("idle_both_x1", 32'(xo1), 320);
        pulse(1'b1, 1'b1);
        check("run_both_state", 32'(game_state), 1);
        check("run_both_x1", 32'(xo1), 318);

        // Asynchronous reset between clock edges
        #3 rst = 1'b1;
        #1;
        check("async_x1", 32'(xo1), 320);
        check("async_state", 32'(game_state), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("async_hold_x1", 32'(xo1), 320);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
